fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one word-aligned read at a time to the
// instruction memory, buffers the returned word for decode, and handles
// branch redirects (including wrong-path requests still in flight) and a
// sticky halt that stops fetch until reset.
//
// Handshakes:
//   imem: imem_req/imem_addr are raised and held stable until the cycle in
//         which imem_ack=1; that cycle also carries imem_rdata. An ack while
//         imem_req=0 has no effect.
//   decode: an instruction moves to decode in a cycle where id_valid=1 and
//         id_ready=1. While id_valid=1 and id_ready=0 every id_* output holds.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rt,
  output logic [5:0]  id_funct,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        halted,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // request for pc outstanding
    S_DROP = 2'd1,  // wrong-path request outstanding, pc already retargeted
    S_HOLD = 2'd2,  // instruction buffered for decode
    S_HALT = 2'd3   // stopped until reset
  } state_t;

  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] idpc_q, idpc_d;
  logic        hp_q, hp_d;
  logic        req_q, req_d;
  logic        halted_q, halted_d;

  logic        halt_any;
  logic        redir;
  logic [31:0] target;
  logic        unused_bits;

  // A halt (new or pending) blocks every redirect; target drops the byte offset.
  assign halt_any    = halt | hp_q;
  assign redir       = redirect_en & ~halt_any;
  assign target      = {redirect_pc[31:2], 2'b00};
  assign unused_bits = ^redirect_pc[1:0];

  // Next-state logic for the fetch FSM and its registered outputs.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    idpc_d  = idpc_q;
    hp_d    = hp_q | halt;
    case (state_q)
      S_REQ: begin
        if (imem_ack) begin
          if (halt_any) begin
            state_d = S_HALT;
          end else if (redir) begin
            pc_d    = target;
            state_d = S_REQ;
          end else begin
            inst_d  = imem_rdata;
            idpc_d  = pc_q;
            state_d = S_HOLD;
          end
        end else if (redir) begin
          pc_d    = target;
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (redir) pc_d = target;
        if (imem_ack) state_d = halt_any ? S_HALT : S_REQ;
      end
      S_HOLD: begin
        if (halt_any) begin
          state_d = S_HALT;
        end else if (redir) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (id_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_HALT;
    endcase
    // A fresh request always presents pc; a wrong-path request keeps its address.
    addr_d   = (state_d == S_REQ) ? pc_d : addr_q;
    req_d    = (state_d == S_REQ) || (state_d == S_DROP);
    halted_d = (state_d == S_HALT);
  end

  // State and output registers; reset abandons any outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC_W;
      addr_q   <= RESET_PC_W;
      inst_q   <= 32'd0;
      idpc_q   <= 32'd0;
      hp_q     <= 1'b0;
      req_q    <= 1'b1;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      inst_q   <= inst_d;
      idpc_q   <= idpc_d;
      hp_q     <= hp_d;
      req_q    <= req_d;
      halted_q <= halted_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign halted    = halted_q;
  assign dbg_state = state_q;
  // A same-cycle redirect squashes the buffered instruction.
  assign id_valid  = (state_q == S_HOLD) & ~redirect_en;
  assign id_inst   = inst_q;
  assign id_opcode = inst_q[31:26];
  assign id_rt     = inst_q[20:16];
  assign id_funct  = inst_q[5:0];
  assign id_pc     = idpc_q;
  assign id_pc4    = idpc_q + 32'd4;

endmodule
